fifo_feed_ctrl: RTL



---
 rtl/fifo_feed_ctrl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/fifo_feed_ctrl.sv
// Streams len 64-bit words from 128-bit memory lines into a 2-deep dual-write
// fifo, tracking fifo occupancy locally to choose between paired and single writes.
module fifo_feed_ctrl #(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [LEN_W-1:0]  len_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [127:0]      mem_rdata_i,
    output logic              fifo_w2entry_o,
    output logic [127:0]      fifo_wd_o,
    output logic              fifo_wen_o,
    output logic              fifo_ren_o,
    input  logic              fifo_empty_i,
    input  logic [63:0]       fifo_rd_i,
    output logic              out_valid_o,
    output logic [63:0]       out_data_o,
    input  logic              out_ready_i
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t              state_q, state_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LEN_W-1:0]    lines_left_q, lines_left_d;
    logic [LEN_W-1:0]    delivered_q, delivered_d;
    logic                outstanding_q, outstanding_d;
    logic [127:0]        hold_q, hold_d;
    logic                hold_valid_q, hold_valid_d;
    logic                hold_two_q, hold_two_d;   // hold_cnt==2
    logic [1:0]          occ_q, occ_d;

    logic       rd_eff;
    logic [1:0] space;
    logic [1:0] wr_words;

    assign out_valid_o = ~fifo_empty_i;
    assign out_data_o  = fifo_rd_i;
    assign fifo_ren_o  = out_valid_o & out_ready_i;
    assign fifo_wd_o   = hold_q;
    assign mem_addr_o  = addr_q;
    assign busy_o      = (state_q != IDLE);
    assign done_o      = (state_q == DONE);

    // Reads only count against the model when it believes the fifo holds data.
    assign rd_eff = fifo_ren_o & (occ_q != 2'd0);
    assign space  = 2'd2 - occ_q + {1'b0, rd_eff};

    always_comb begin
        state_d        = state_q;
        len_d          = len_q;
        addr_d         = addr_q;
        lines_left_d   = lines_left_q;
        delivered_d    = delivered_q;
        outstanding_d  = outstanding_q;
        hold_d         = hold_q;
        hold_valid_d   = hold_valid_q;
        hold_two_d     = hold_two_q;
        fifo_wen_o     = 1'b0;
        fifo_w2entry_o = 1'b0;
        wr_words       = 2'd0;

        mem_req_o = (state_q == RUN) && (lines_left_q != '0) && !outstanding_q && !hold_valid_q;

        if (hold_valid_q && space != 2'd0) begin
            fifo_wen_o = 1'b1;
            if (hold_two_q && space == 2'd2) begin
                fifo_w2entry_o = 1'b1;
                wr_words       = 2'd2;
                hold_valid_d   = 1'b0;
            end else if (hold_two_q) begin
                wr_words       = 2'd1;
                hold_d[63:0]   = hold_q[127:64];
                hold_two_d     = 1'b0;
            end else begin
                wr_words       = 2'd1;
                hold_valid_d   = 1'b0;
            end
        end
        occ_d = occ_q + wr_words - {1'b0, rd_eff};

        if (mem_req_o && mem_gnt_i) begin
            outstanding_d = 1'b1;
            addr_d        = addr_q + ADDR_W'(16);
            lines_left_d  = lines_left_q - LEN_W'(1);
        end

        // Only one line is ever in flight, so lines_left==0 marks the last one.
        if (outstanding_q && mem_rvalid_i && state_q == RUN) begin
            hold_d        = mem_rdata_i;
            hold_valid_d  = 1'b1;
            outstanding_d = 1'b0;
            hold_two_d    = !(lines_left_q == '0 && len_q[0]);
        end

        if (busy_o && fifo_ren_o)
            delivered_d = delivered_q + LEN_W'(1);

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    len_d        = len_i;
                    addr_d       = base_addr_i;
                    lines_left_d = (len_i >> 1) + LEN_W'(len_i[0]);
                    delivered_d  = '0;
                    state_d      = (len_i != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (lines_left_q == '0 && !outstanding_q && !hold_valid_q)
                    state_d = DRAIN;
            end
            DRAIN: begin
                if (delivered_q == len_q)
                    state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            len_q         <= '0;
            addr_q        <= '0;
            lines_left_q  <= '0;
            delivered_q   <= '0;
            outstanding_q <= 1'b0;
            hold_q        <= '0;
            hold_valid_q  <= 1'b0;
            hold_two_q    <= 1'b0;
            occ_q         <= '0;
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            addr_q        <= addr_d;
            lines_left_q  <= lines_left_d;
            delivered_q   <= delivered_d;
            outstanding_q <= outstanding_d;
            hold_q        <= hold_d;
            hold_valid_q  <= hold_valid_d;
            hold_two_q    <= hold_two_d;
            occ_q         <= occ_d;
        end
    end

endmodule
